wb_stage: RTL

Writeback stage of the five-stage WISC-SP13 pipeline, the producer end of the register-file write port that the decode stage consumes. It latches the MEM/WB pipeline register and selects the write-back value from ALU result, load data or link address. It resolves the destination register from the 2-bit register-destination code and drives `write_data`/`reg_wr_sel`/`reg_write` into the decode stage's bypassing register file. It also owns retirement: a retired-instruction counter, a halt state machine triggered by a retiring `dump` (HALT), and sticky error reporting.

---
 rtl/wb_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the WISC-SP13 pipeline.
// Latches MEM/WB, selects the write-back value and destination register,
// and owns retirement (retired counter, HALT/ERROR state machine).
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_alu_out,
  input  logic [15:0] in_mem_data,
  input  logic [15:0] in_pc_inc,
  input  logic        in_mem_to_reg,
  input  logic        in_link,
  input  logic        in_reg_write,
  input  logic [1:0]  in_reg_dst,
  input  logic        in_dump,
  input  logic        in_err,
  output logic [15:0] write_data,
  output logic [2:0]  reg_wr_sel,
  output logic        reg_write,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } state_e;

  // Only instr[10:2] (Rs, Rt, Rd fields) is ever consumed, so only those bits are kept.
  typedef struct packed {
    logic        valid;
    logic [8:0]  rf_fields;   // in_instr[10:2]
    logic [15:0] alu_out;
    logic [15:0] mem_data;
    logic [15:0] pc_inc;
    logic        mem_to_reg;
    logic        link;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        dump;
    logic        err_flag;
  } latch_t;

  latch_t      l_q, l_d;
  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        run;
  logic        retire;

  // Opcode and function bits of the instruction carry no writeback meaning.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[15:11], in_instr[1:0]};

  assign run    = (state_q == ST_RUN);
  assign retire = run & l_q.valid & ~l_q.err_flag;

  // MEM/WB latch next value: a stall or a stopped machine turns the slot into a bubble.
  always_comb begin
    l_d            = '0;
    l_d.valid      = in_valid & ~stall & run;
    l_d.rf_fields  = in_instr[10:2];
    l_d.alu_out    = in_alu_out;
    l_d.mem_data   = in_mem_data;
    l_d.pc_inc     = in_pc_inc;
    l_d.mem_to_reg = in_mem_to_reg;
    l_d.link       = in_link;
    l_d.reg_write  = in_reg_write;
    l_d.reg_dst    = in_reg_dst;
    l_d.dump       = in_dump;
    l_d.err_flag   = in_err;
  end

  // Retirement state machine and counter next-state; error takes priority over HALT.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    count_d = count_q + {15'd0, retire};
    case (state_q)
      ST_RUN: begin
        if (l_q.valid && l_q.err_flag)  state_d = ST_ERROR;
        else if (l_q.valid && l_q.dump) state_d = ST_HALTED;
      end
      default: state_d = state_q;
    endcase
  end

  // State registers; reset clears the latch so an in-flight write is dropped at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) begin
      l_q     <= '0;
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      l_q     <= l_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Write-back value, destination decode and write enable, all straight from the latch.
  always_comb begin
    write_data = l_q.link       ? l_q.pc_inc   :
                 l_q.mem_to_reg ? l_q.mem_data : l_q.alu_out;
    case (l_q.reg_dst)
      2'b00:   reg_wr_sel = l_q.rf_fields[2:0];   // Rd = instr[4:2]
      2'b01:   reg_wr_sel = l_q.rf_fields[5:3];   // Rt = instr[7:5]
      2'b10:   reg_wr_sel = l_q.rf_fields[8:6];   // Rs = instr[10:8]
      default: reg_wr_sel = 3'd7;                 // link register
    endcase
    reg_write = l_q.valid & l_q.reg_write & ~l_q.dump & ~l_q.err_flag & run;
  end

  assign halted        = (state_q == ST_HALTED);
  assign err           = (state_q == ST_ERROR);
  assign retired_count = count_q;

endmodule
